apb_prci_seq: RTL and testbench



---
 rtl/apb_prci_seq.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_apb_prci_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_prci_seq.sv
// apb_prci_seq: APB reset controller that sequences RST_DOMAINS active-low reset outputs.
// It holds everything in reset until the system PLL lock (i_locked[0]) has been stable for
// LOCK_FILTER cycles, then releases domains one at a time. Software can pulse a single domain,
// or re-sequence all of them. A debug reset request re-asserts all domains.
//
// Optional feature: define PRCI_WATCHDOG_EN to add a watchdog (0x14 reload, 0x18 kick).
//
// Ports:
//   i_clk, i_nrst      clock, asynchronous active-low power-on reset
//   i_dmireset         debug reset request (level, active high, synchronous to i_clk)
//   i_locked           PLL lock / link status, asynchronous, double-flopped here
//   o_dom_nrst         per-domain resets, active low (bit 0 = system domain)
//   o_sys_nrst/o_sys_rst  system domain reset, low / high active
//   o_dbg_nrst         debug module reset, active low
//   i_mapinfo          {addr_end, addr_start} of this slave's slot
//   o_cfg              PnP descriptor {vendor id, device id, i_mapinfo}
//   i_apb_*/o_apb_*    APB slave; response is given one cycle after the access phase starts

`timescale 1ns/1ps

module apb_prci_seq #(
    parameter int unsigned RST_DOMAINS = 4,
    parameter int unsigned LOCK_INPUTS = 3,
    parameter int unsigned DLY_W       = 8,
    parameter int unsigned LOCK_FILTER = 16
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_dmireset,
    input  logic [LOCK_INPUTS-1:0] i_locked,
    output logic [RST_DOMAINS-1:0] o_dom_nrst,
    output logic                   o_sys_nrst,
    output logic                   o_sys_rst,
    output logic                   o_dbg_nrst,
    input  logic [63:0]            i_mapinfo,
    output logic [95:0]            o_cfg,
    input  logic                   i_apb_psel,
    input  logic                   i_apb_penable,
    input  logic                   i_apb_pwrite,
    input  logic [11:0]            i_apb_paddr,
    input  logic [31:0]            i_apb_pwdata,
    output logic [31:0]            o_apb_prdata,
    output logic                   o_apb_pready,
    output logic                   o_apb_pslverr
);

    localparam logic [15:0] VENDOR_OPTIMITECH = 16'h00F1;
    localparam logic [15:0] OPTIMITECH_PRCI   = 16'h0076;
    localparam int unsigned IDX_W = (RST_DOMAINS > 1) ? $clog2(RST_DOMAINS) : 1;
    localparam int unsigned LF_W  = $clog2(LOCK_FILTER + 1);

    typedef enum logic [2:0] {
        StWaitLock = 3'd0,
        StRelease  = 3'd1,
        StRun      = 3'd2,
        StSwrst    = 3'd3,
        StAssert   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       swk_q, swk_d;
    logic [DLY_W-1:0]       cnt_q, cnt_d;
    logic [DLY_W-1:0]       dly_q;
    logic [RST_DOMAINS-1:0] pend_q, pend_d, pend_clr;
    logic [4:0]             cause_q, cause_d;
    logic [RST_DOMAINS-1:0] dom_nrst_q, dom_nrst_d;
    logic                   dbg_nrst_q, dbg_nrst_d;
    logic [LOCK_INPUTS-1:0] lock_s1_q, lock_s2_q;
    logic [LF_W-1:0]        filt_q;
    logic                   lock_ok, lock_lost;
    logic                   set_lock, set_dmi, set_sw, set_wdt, wdt_fire;
    logic [IDX_W-1:0]       low_k;
    logic                   apb_req, apb_wr, wr_pend, wr_dly, wr_cause;
    logic [31:0]            rdata;
    logic [31:0]            prdata_q;
    logic                   pready_q;
    logic                   unused_pwdata;

    // Lock synchroniser and stability filter (saturating count of consecutive high cycles).
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lock_s1_q <= '0;
            lock_s2_q <= '0;
            filt_q    <= '0;
        end else begin
            lock_s1_q <= i_locked;
            lock_s2_q <= lock_s1_q;
            if (!lock_s2_q[0]) begin
                filt_q <= '0;
            end else if (!lock_ok) begin
                filt_q <= filt_q + 1'b1;
            end
        end
    end

    assign lock_ok   = (filt_q == LF_W'(LOCK_FILTER));
    assign lock_lost = ~lock_s2_q[0];

    // APB decode: a request is the first cycle of the access phase.
    assign apb_req  = i_apb_psel & i_apb_penable & ~pready_q;
    assign apb_wr   = apb_req & i_apb_pwrite;
    assign wr_pend  = apb_wr && (i_apb_paddr == 12'h008);
    assign wr_dly   = apb_wr && (i_apb_paddr == 12'h00C);
    assign wr_cause = apb_wr && (i_apb_paddr == 12'h010);

`ifdef PRCI_WATCHDOG_EN
    logic [31:0] wdt_reload_q, wdt_cnt_q;
    logic        wr_wdt_reload, wr_wdt_kick;

    assign wr_wdt_reload = apb_wr && (i_apb_paddr == 12'h014);
    assign wr_wdt_kick   = apb_wr && (i_apb_paddr == 12'h018);
    // Fires on the cycle the count would reach zero, i.e. 'reload' RUN cycles after a reload.
    assign wdt_fire = (state_q == StRun) && (wdt_reload_q != 32'd0) && (wdt_cnt_q <= 32'd1);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wdt_reload_q <= '0;
            wdt_cnt_q    <= '0;
        end else if (wr_wdt_reload) begin
            wdt_reload_q <= i_apb_pwdata;
            wdt_cnt_q    <= i_apb_pwdata;
        end else if (wr_wdt_kick || wdt_fire) begin
            wdt_cnt_q <= wdt_reload_q;
        end else if (state_q == StRun && wdt_reload_q != 32'd0) begin
            wdt_cnt_q <= wdt_cnt_q - 32'd1;
        end
    end
`else
    assign wdt_fire = 1'b0;
`endif

    // Lowest pending domain.
    always_comb begin
        low_k = '0;
        for (int i = RST_DOMAINS - 1; i >= 0; i--) begin
            if (pend_q[i]) low_k = IDX_W'(i);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= StWaitLock;
            idx_q   <= '0;
            swk_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            swk_q   <= swk_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state. Lock loss beats debug reset, which beats watchdog and software requests.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        swk_d    = swk_q;
        cnt_d    = cnt_q;
        pend_clr = '0;
        set_lock = 1'b0;
        set_dmi  = 1'b0;
        set_sw   = 1'b0;
        set_wdt  = 1'b0;
        if (state_q != StWaitLock && lock_lost) begin
            state_d  = StWaitLock;
            set_lock = 1'b1;
        end else if (state_q != StWaitLock && i_dmireset) begin
            state_d = StAssert;
            set_dmi = 1'b1;
        end else begin
            case (state_q)
                StWaitLock: begin
                    if (lock_ok && !i_dmireset) begin
                        state_d = StRelease;
                        idx_d   = '0;
                        cnt_d   = dly_q;
                    end
                end
                StRelease: begin
                    if (cnt_q == '0) begin
                        if (idx_q == IDX_W'(RST_DOMAINS - 1)) begin
                            state_d = StRun;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            cnt_d = dly_q;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StRun: begin
                    if (wdt_fire) begin
                        state_d = StAssert;
                        set_wdt = 1'b1;
                    end else if (|pend_q) begin
                        set_sw = 1'b1;
                        if (pend_q[0]) begin
                            // System domain request means a full re-sequence.
                            state_d  = StAssert;
                            pend_clr = '1;
                        end else begin
                            state_d  = StSwrst;
                            swk_d    = low_k;
                            cnt_d    = dly_q;
                            pend_clr = RST_DOMAINS'(1) << low_k;
                        end
                    end
                end
                StSwrst: begin
                    if (cnt_q == '0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StAssert: begin
                    state_d = StRelease;
                    idx_d   = '0;
                    cnt_d   = dly_q;
                end
                default: state_d = StWaitLock;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered so reset lines never glitch.
    always_comb begin
        dom_nrst_d = '0;
        case (state_d)
            StRelease: begin
                for (int i = 0; i < RST_DOMAINS; i++) begin
                    dom_nrst_d[i] = (IDX_W'(i) < idx_d);
                end
            end
            StRun:   dom_nrst_d = '1;
            StSwrst: begin
                dom_nrst_d        = '1;
                dom_nrst_d[swk_d] = 1'b0;
            end
            default: dom_nrst_d = '0;
        endcase
        dbg_nrst_d = (state_d != StWaitLock);
    end

    // Pending mask and sticky cause; new events win over a same-cycle W1C.
    always_comb begin
        pend_d = (pend_q & ~pend_clr) | (wr_pend ? i_apb_pwdata[RST_DOMAINS-1:0] : '0);
        cause_d = cause_q;
        if (wr_cause) cause_d = cause_q & ~i_apb_pwdata[4:0];
        cause_d = cause_d | {set_wdt, set_sw, set_dmi, set_lock, 1'b0};
    end

    always_comb begin
        rdata = '0;
        case (i_apb_paddr)
            12'h000: begin
                rdata[LOCK_INPUTS-1:0] = lock_s2_q;
                rdata[31]              = lock_ok;
            end
            12'h004: begin
                rdata[RST_DOMAINS-1:0] = dom_nrst_q;
                rdata[16]              = dbg_nrst_q;
                rdata[26:24]           = state_q;
            end
            12'h008: rdata[RST_DOMAINS-1:0] = pend_q;
            12'h00C: rdata[DLY_W-1:0] = dly_q;
            12'h010: rdata[4:0] = cause_q;
`ifdef PRCI_WATCHDOG_EN
            12'h014: rdata = wdt_reload_q;
`endif
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            dom_nrst_q <= '0;
            dbg_nrst_q <= 1'b0;
            pend_q     <= '0;
            cause_q    <= 5'b00001;
            dly_q      <= DLY_W'(16);
            prdata_q   <= '0;
            pready_q   <= 1'b0;
        end else begin
            dom_nrst_q <= dom_nrst_d;
            dbg_nrst_q <= dbg_nrst_d;
            pend_q     <= pend_d;
            cause_q    <= cause_d;
            if (wr_dly) dly_q <= i_apb_pwdata[DLY_W-1:0];
            if (apb_req) prdata_q <= rdata;
            pready_q <= apb_req;
        end
    end

    assign o_dom_nrst    = dom_nrst_q;
    assign o_sys_nrst    = dom_nrst_q[0];
    assign o_sys_rst     = ~dom_nrst_q[0];
    assign o_dbg_nrst    = dbg_nrst_q;
    assign o_cfg         = {VENDOR_OPTIMITECH, OPTIMITECH_PRCI, i_mapinfo};
    assign o_apb_prdata  = prdata_q;
    assign o_apb_pready  = pready_q;
    assign o_apb_pslverr = 1'b0;
    assign unused_pwdata = ^i_apb_pwdata;

endmodule

// File: tb/tb_apb_prci_seq.sv
// Self-checking bench for apb_prci_seq (default parameters). Expected event times come from
// the release-timing rules: sync latency 2, LOCK_FILTER stable cycles, then domain k after
// (k+1)*(D+1) cycles; pulse lengths D+1. Output edges are timestamped by a negedge monitor.

`timescale 1ns/1ps

module tb_apb_prci_seq;

    localparam int N    = 4;
    localparam int LF   = 16;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        nrst, dmireset;
    logic [2:0]  locked;
    logic [3:0]  dom_nrst;
    logic        sys_nrst, sys_rst, dbg_nrst;
    logic [95:0] cfg;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;

    apb_prci_seq dut (
        .i_clk        (clk),
        .i_nrst       (nrst),
        .i_dmireset   (dmireset),
        .i_locked     (locked),
        .o_dom_nrst   (dom_nrst),
        .o_sys_nrst   (sys_nrst),
        .o_sys_rst    (sys_rst),
        .o_dbg_nrst   (dbg_nrst),
        .i_mapinfo    (64'h0000_0fff_0000_0000),
        .o_cfg        (cfg),
        .i_apb_psel   (psel),
        .i_apb_penable(penable),
        .i_apb_pwrite (pwrite),
        .i_apb_paddr  (paddr),
        .i_apb_pwdata (pwdata),
        .o_apb_prdata (prdata),
        .o_apb_pready (pready),
        .o_apb_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: bits 0..3 = domains, bit 4 = dbg.
    logic [4:0] mon_prev = '0;
    logic [4:0] obs;
    int rise_t [5];
    int fall_t [5];
    int nrise  [5];
    int nfall  [5];
    initial for (int b = 0; b < 5; b++) begin rise_t[b] = -1; fall_t[b] = -1; nrise[b] = 0;
        nfall[b] = 0; end
    assign obs = {dbg_nrst, dom_nrst};
    always @(negedge clk) begin
        for (int b = 0; b < 5; b++) begin
            if (!mon_prev[b] && obs[b]) begin rise_t[b] <= cyc; nrise[b] <= nrise[b] + 1; end
            if (mon_prev[b] && !obs[b]) begin fall_t[b] <= cyc; nfall[b] <= nfall[b] + 1; end
        end
        mon_prev <= obs;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!pready && n < 8);
        check_eq("apb_ready", {31'b0, pready}, 32'd1);
        check_eq("apb_slverr", {31'b0, pslverr}, 32'd0);
        rdata = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        logic [31:0] dummy;
        apb_xfer(1'b1, addr, data, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_xfer(1'b0, addr, 32'h0, d);
        check_eq(tag, d, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reads the cause, compares, then clears it.
    task automatic cause_check(input string tag, input logic [31:0] exp);
        rd_check(tag, 12'h010, exp);
        wr(12'h010, 32'h1f);
    endtask

    int d, k, t, t2, s, e, g, len;
    int nf0 [5];
    int nr0 [5];
    logic [2:0] lk;

    task automatic snap();
        for (int b = 0; b < 5; b++) begin nf0[b] = nfall[b]; nr0[b] = nrise[b]; end
    endtask

    initial begin
        nrst = 1'b0; dmireset = 1'b0; locked = 3'b000;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        step(3);
        check_eq("rst_dom", {28'b0, dom_nrst}, 32'h0);
        check_eq("rst_sys_nrst", {31'b0, sys_nrst}, 32'h0);
        check_eq("rst_sys_rst", {31'b0, sys_rst}, 32'h1);
        check_eq("rst_dbg", {31'b0, dbg_nrst}, 32'h0);
        nrst = 1'b1;
        rd_check("rst_status", 12'h004, 32'h0);
        rd_check("rst_delay", 12'h00C, 32'd16);
        rd_check("rst_pend", 12'h008, 32'h0);
        rd_check("rst_cause", 12'h010, 32'h1);
        check_eq("cfg_ids", cfg[95:64], 32'h00F1_0076);

        // Lock glitch shorter than the filter must not start the release.
        snap();
        g = $urandom_range(1, LF - 1);
        locked = 3'b001;
        step(g);
        locked = 3'b000;
        step(30);
        check_eq("filter_short", nrise[4] - nr0[4], 0);

        // Power-up sequence with the default delay of 16.
        d = 16;
        lk = {$urandom_range(0, 3) > 1, $urandom_range(0, 1) == 1, 1'b1};
        step(1);
        locked = lk;
        t = cyc;
        step(SYNC + LF + 1 + N * (d + 1) + 10);
        check_eq("pwr_dbg_time", rise_t[4] - t, SYNC + LF + 1);
        for (int i = 0; i < N; i++) check_eq("pwr_dom_time", rise_t[i] - rise_t[4], (i + 1) * (d + 1));
        check_eq("pwr_sys", {30'b0, sys_nrst, sys_rst}, 32'h2);
        rd_check("run_status", 12'h004, 32'h0201_000F);
        rd_check("lock_status", 12'h000, {29'b0, lk} | 32'h8000_0000);
        cause_check("pwr_cause", 32'h1);
        rd_check("cause_clr", 12'h010, 32'h0);

        // Single-domain software pulses.
        for (int it = 0; it < 5; it++) begin
            d = (it == 0) ? 3 : $urandom_range(0, 7);
            k = (it == 0) ? 2 : $urandom_range(1, N - 1);
            wr(12'h00C, d);
            rd_check("sw_delay_rd", 12'h00C, d);
            snap();
            wr(12'h008, 32'(1) << k);
            step(d + 10);
            check_eq("sw_low_len", rise_t[k] - fall_t[k], d + 1);
            check_eq("sw_target_cnt", nfall[k] - nf0[k], 1);
            len = 0;
            for (int b = 0; b < 5; b++) if (b != k) len += nfall[b] - nf0[b];
            check_eq("sw_others", len, 0);
            rd_check("sw_pend_clr", 12'h008, 32'h0);
        end
        cause_check("sw_cause", 32'h8);

        // Request 0x6 while domain 1 is in its pulse: 1 is pending again, then 2; no overlap.
        d = 10;
        wr(12'h00C, d);
        snap();
        wr(12'h008, 32'h2);
        wr(12'h008, 32'h6);
        step(3 * (d + 2) + 10);
        check_eq("ovl_dom1_cnt", nfall[1] - nf0[1], 2);
        check_eq("ovl_dom2_cnt", nfall[2] - nf0[2], 1);
        check_eq("ovl_order", {31'b0, fall_t[2] > rise_t[1]}, 32'h1);
        check_eq("ovl_dom2_len", rise_t[2] - fall_t[2], d + 1);
        check_eq("ovl_others", (nfall[0] - nf0[0]) + (nfall[3] - nf0[3]) + (nfall[4] - nf0[4]), 0);
        cause_check("ovl_cause", 32'h8);

        // System-domain request: full re-sequence, debug untouched.
        d = $urandom_range(0, 5);
        wr(12'h00C, d);
        snap();
        wr(12'h008, 32'h1);
        step(N * (d + 1) + 10);
        for (int i = 0; i < N; i++) begin
            check_eq("sw0_fall", fall_t[i], fall_t[0]);
            check_eq("sw0_rise", rise_t[i] - fall_t[0], 1 + (i + 1) * (d + 1));
        end
        check_eq("sw0_dbg", nfall[4] - nf0[4], 0);
        rd_check("sw0_pend", 12'h008, 32'h0);
        cause_check("sw0_cause", 32'h8);

        // Debug reset pulse.
        d = $urandom_range(0, 6);
        wr(12'h00C, d);
        snap();
        len = $urandom_range(3, 12);
        step(1);
        dmireset = 1'b1;
        s = cyc;
        step(2);
        check_eq("dmi_dom_low", {28'b0, dom_nrst}, 32'h0);
        check_eq("dmi_dbg_high", {31'b0, dbg_nrst}, 32'h1);
        step(len - 2);
        dmireset = 1'b0;
        e = cyc;
        step(N * (d + 1) + 10);
        check_eq("dmi_fall", fall_t[0] - s, 1);
        for (int i = 0; i < N; i++) check_eq("dmi_rise", rise_t[i] - e, 1 + (i + 1) * (d + 1));
        check_eq("dmi_dbg_cnt", nfall[4] - nf0[4], 0);
        cause_check("dmi_cause", 32'h4);

        // One-cycle lock loss in RUN.
        snap();
        step(1);
        locked[0] = 1'b0;
        t = cyc;
        step(1);
        locked[0] = 1'b1;
        t2 = cyc;
        step(SYNC + LF + 1 + N * (d + 1) + 10);
        check_eq("lol_dom_fall", fall_t[0] - t, SYNC + 1);
        check_eq("lol_dom3_fall", fall_t[3] - t, SYNC + 1);
        check_eq("lol_dbg_fall", fall_t[4] - t, SYNC + 1);
        check_eq("lol_dbg_rise", rise_t[4] - t2, SYNC + LF + 1);
        check_eq("lol_dom3_rise", rise_t[3] - rise_t[4], N * (d + 1));
        cause_check("lol_cause", 32'h2);

        // Unmapped space.
        wr(12'h020, 32'hffff_ffff);
        rd_check("unmapped_rd", 12'h020, 32'h0);
        rd_check("delay_kept", 12'h00C, d);
`ifdef PRCI_WATCHDOG_EN
        wr(12'h014, 32'd100);
        rd_check("wdt_reload_rd", 12'h014, 32'd100);
        snap();
        for (int i = 0; i < 6; i++) begin
            step(45);
            wr(12'h018, 32'h0);
        end
        check_eq("wdt_kicked", nfall[0] - nf0[0], 0);
        snap();
        wr(12'h014, 32'd100);
        t = cyc;
        step(130);
        check_eq("wdt_fire_cnt", nfall[0] - nf0[0], 1);
        check_eq("wdt_fire_time", fall_t[0] - t, 99);
        check_eq("wdt_dbg", nfall[4] - nf0[4], 0);
        wr(12'h014, 32'd0);
        cause_check("wdt_cause", 32'h10);
`else
        wr(12'h014, 32'd100);
        rd_check("wdt_absent_rd", 12'h014, 32'h0);
        step(150);
        rd_check("wdt_absent_cause", 12'h010, 32'h0);
`endif
        rd_check("final_status", 12'h004, 32'h0201_000F);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
